// File: rtl/iir_axil_regs.sv
// AXI4-Lite control/status register block for a first-order IIR filter.
// Holds the enable bit, the three Q1.15 coefficients and generates a
// one-cycle filter-state clear pulse. Write address and data are accepted
// independently and paired up in skid registers; reads run on their own path.
module iir_axil_regs #(
  parameter int                 C_S_AXI_ADDR_WIDTH = 4,
  parameter int                 C_S_AXI_DATA_WIDTH = 32,
  parameter logic signed [15:0] B0_RESET           = 16'sd32767
) (
  input  logic                              aclk,
  input  logic                              areset,
  // write address / data / response
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [3:0]                        s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  // read address / data
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  // filter-facing outputs
  output logic signed [15:0]                coef_b0,
  output logic signed [15:0]                coef_b1,
  output logic signed [15:0]                coef_a1,
  output logic                              filt_enable,
  output logic                              state_clear
);

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_B0   = 2'd1;
  localparam logic [1:0] REG_B1   = 2'd2;
  localparam logic [1:0] REG_A1   = 2'd3;

  // Only the low halfword, the two low strobes and address bits [3:2] matter.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_wstrb};

  // Write path state
  logic        aw_held_q, aw_held_d;
  logic [1:0]  aw_idx_q, aw_idx_d;
  logic        w_held_q, w_held_d;
  logic [15:0] w_data_q, w_data_d;
  logic [1:0]  w_strb_q, w_strb_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic        en_q, en_d;
  logic [15:0] b0_q, b0_d, b1_q, b1_d, a1_q, a1_d;
  logic        clr_q, clr_d;

  // Read path state
  logic                          arready_q, arready_d;
  logic                          rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic        aw_hs, w_hs, commit, ar_hs;
  logic [1:0]  wr_idx;
  logic [15:0] wr_data;
  logic [1:0]  wr_strb;

  // Byte-lane merge of a 16-bit register with the write data.
  function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                          input logic [15:0] new_v,
                                          input logic [1:0]  strb);
    logic [15:0] res;
    res        = old_v;
    if (strb[0]) res[7:0]  = new_v[7:0];
    if (strb[1]) res[15:8] = new_v[15:8];
    return res;
  endfunction

  // Write path: pair AW/W halves, commit to registers, manage B response.
  always_comb begin
    aw_hs    = s_axi_awvalid && awready_q;
    w_hs     = s_axi_wvalid && wready_q;
    wr_idx   = aw_held_q ? aw_idx_q : s_axi_awaddr[3:2];
    wr_data  = w_held_q ? w_data_q : s_axi_wdata[15:0];
    wr_strb  = w_held_q ? w_strb_q : s_axi_wstrb[1:0];
    commit   = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    aw_held_d = commit ? 1'b0 : (aw_held_q || aw_hs);
    aw_idx_d  = aw_hs ? s_axi_awaddr[3:2] : aw_idx_q;
    w_held_d  = commit ? 1'b0 : (w_held_q || w_hs);
    w_data_d  = w_hs ? s_axi_wdata[15:0] : w_data_q;
    w_strb_d  = w_hs ? s_axi_wstrb[1:0] : w_strb_q;

    bvalid_d  = commit ? 1'b1 : (bvalid_q && !s_axi_bready);
    // Readies are registered from next-state so no input reaches them combinationally.
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;

    en_d  = en_q;
    b0_d  = b0_q;
    b1_d  = b1_q;
    a1_d  = a1_q;
    clr_d = 1'b0;
    if (commit) begin
      case (wr_idx)
        REG_CTRL: begin
          if (wr_strb[0]) begin
            en_d  = wr_data[0];
            clr_d = wr_data[1];
          end
        end
        REG_B0:  b0_d = merge16(b0_q, wr_data, wr_strb);
        REG_B1:  b1_d = merge16(b1_q, wr_data, wr_strb);
        REG_A1:  a1_d = merge16(a1_q, wr_data, wr_strb);
        default: ;
      endcase
    end
  end

  // Read path: capture register contents (pre-write values) on AR handshake.
  always_comb begin
    ar_hs     = s_axi_arvalid && arready_q;
    rvalid_d  = ar_hs ? 1'b1 : (rvalid_q && !s_axi_rready);
    arready_d = !rvalid_d;
    rdata_d   = rdata_q;
    if (ar_hs) begin
      rdata_d = '0;
      case (s_axi_araddr[3:2])
        REG_CTRL: rdata_d[0]    = en_q;
        REG_B0:   rdata_d[15:0] = b0_q;
        REG_B1:   rdata_d[15:0] = b1_q;
        REG_A1:   rdata_d[15:0] = a1_q;
        default:  ;
      endcase
    end
  end

  // State registers; reset drops any half-finished transaction.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= 2'd0;
      w_held_q  <= 1'b0;
      w_data_q  <= 16'd0;
      w_strb_q  <= 2'd0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      en_q      <= 1'b0;
      b0_q      <= B0_RESET;
      b1_q      <= 16'd0;
      a1_q      <= 16'd0;
      clr_q     <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      en_q      <= en_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      a1_q      <= a1_d;
      clr_q     <= clr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign coef_b0       = b0_q;
  assign coef_b1       = b1_q;
  assign coef_a1       = a1_q;
  assign filt_enable   = en_q;
  assign state_clear   = clr_q;

endmodule

// File: tb/tb_iir_axil_regs.sv
// Self-checking bench for iir_axil_regs: directed scenarios plus randomized
// reads/writes checked against a register-map model.
module tb_iir_axil_regs;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  s_axi_awaddr;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready;
  logic [15:0] coef_b0, coef_b1, coef_a1;
  logic        filt_enable, state_clear;

  int checks = 0;
  int errors = 0;

  // Model of the register map: enable bit and the three coefficients.
  bit          m_en;
  logic [15:0] m_coef [1:3];

  iir_axil_regs dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .coef_b0(coef_b0), .coef_b1(coef_b1), .coef_a1(coef_a1),
    .filt_enable(filt_enable), .state_clear(state_clear)
  );

  always #5 aclk = ~aclk;

  function automatic void model_reset();
    m_en      = 1'b0;
    m_coef[1] = 16'h7FFF;
    m_coef[2] = 16'h0000;
    m_coef[3] = 16'h0000;
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
    if (idx == 0) begin
      if (strb[0]) m_en = data[0];
    end else begin
      if (strb[0]) m_coef[idx][7:0]  = data[7:0];
      if (strb[1]) m_coef[idx][15:8] = data[15:8];
    end
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    if (idx == 0) return {31'd0, m_en};
    return {16'd0, m_coef[idx]};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Full write: AW offered after awd cycles, W after wd cycles, bready held low bd cycles.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awd, input int wd, input int bd);
    int c;
    bit aw_done, w_done, aw_hs, w_hs, exp_clr;
    int idx;
    idx = int'(addr[3:2]);
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    c = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && c < 40) begin
      s_axi_awvalid = !aw_done && (c >= awd);
      s_axi_wvalid  = !w_done && (c >= wd);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      tick();
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      c++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    checks++;
    if (!(aw_done && w_done)) begin
      errors++;
      $display("FAIL write_handshake timeout: aw_done=%0b w_done=%0b required both 1", aw_done, w_done);
      return;
    end
    exp_clr = (idx == 0) && strb[0] && data[1];
    model_write(idx, data, strb);
    checks++; if (s_axi_bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_after_commit got %b want 1", s_axi_bvalid); end
    checks++; if (s_axi_bresp !== 2'b00) begin errors++; $display("FAIL bresp got %b want 00", s_axi_bresp); end
    checks++; if ({coef_b0, coef_b1, coef_a1} !== {m_coef[1], m_coef[2], m_coef[3]}) begin
      errors++; $display("FAIL coefs got %h %h %h want %h %h %h", coef_b0, coef_b1, coef_a1, m_coef[1], m_coef[2], m_coef[3]); end
    checks++; if (filt_enable !== m_en) begin errors++; $display("FAIL filt_enable got %b want %b", filt_enable, m_en); end
    checks++; if (state_clear !== exp_clr) begin errors++; $display("FAIL state_clear_pulse got %b want %b", state_clear, exp_clr); end
    checks++; if ({s_axi_awready, s_axi_wready} !== 2'b00) begin errors++; $display("FAIL ready_during_b got %b want 00", {s_axi_awready, s_axi_wready}); end
    for (int i = 0; i < bd; i++) begin
      tick();
      checks++; if ({s_axi_bvalid, s_axi_awready, s_axi_wready, state_clear} !== 4'b1000) begin
        errors++; $display("FAIL b_hold cycle %0d got bvalid/awready/wready/clr=%b want 1000", i, {s_axi_bvalid, s_axi_awready, s_axi_wready, state_clear}); end
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    checks++; if ({s_axi_bvalid, s_axi_awready, s_axi_wready, state_clear} !== 4'b0110) begin
      errors++; $display("FAIL b_release got bvalid/awready/wready/clr=%b want 0110", {s_axi_bvalid, s_axi_awready, s_axi_wready, state_clear}); end
    $display("write addr=%h data=%h strb=%b awd=%0d wd=%0d bd=%0d", addr, data, strb, awd, wd, bd);
  endtask

  // Full read with rready held low rd cycles; data must stay stable meanwhile.
  task automatic do_read(input logic [3:0] addr, input int rd);
    int c;
    logic [31:0] exp;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    c = 0;
    while (!s_axi_arready && c < 20) begin tick(); c++; end
    if (!s_axi_arready) begin
      checks++; errors++;
      s_axi_arvalid = 1'b0;
      $display("FAIL arready_wait timeout got 0 want 1");
      return;
    end
    tick();
    s_axi_arvalid = 1'b0;
    exp = model_read(int'(addr[3:2]));
    checks++; if (s_axi_rvalid !== 1'b1) begin errors++; $display("FAIL rvalid got %b want 1", s_axi_rvalid); end
    checks++; if (s_axi_rresp !== 2'b00) begin errors++; $display("FAIL rresp got %b want 00", s_axi_rresp); end
    checks++; if (s_axi_rdata !== exp) begin errors++; $display("FAIL rdata addr=%h got %h want %h", addr, s_axi_rdata, exp); end
    checks++; if (s_axi_arready !== 1'b0) begin errors++; $display("FAIL arready_busy got %b want 0", s_axi_arready); end
    for (int i = 0; i < rd; i++) begin
      tick();
      checks++; if ({s_axi_rvalid, s_axi_rdata} !== {1'b1, exp}) begin
        errors++; $display("FAIL r_hold got %b/%h want 1/%h", s_axi_rvalid, s_axi_rdata, exp); end
    end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    checks++; if ({s_axi_rvalid, s_axi_arready} !== 2'b01) begin
      errors++; $display("FAIL r_release got rvalid/arready=%b want 01", {s_axi_rvalid, s_axi_arready}); end
    $display("read  addr=%h data=%h rd=%0d", addr, exp, rd);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) tick();
    model_reset();
    checks++; if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got %b want 00000", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}); end
    checks++; if ({s_axi_rdata, state_clear, filt_enable} !== 34'd0) begin
      errors++; $display("FAIL reset_rdata_ctrl got %h/%b/%b want 0", s_axi_rdata, state_clear, filt_enable); end
    checks++; if ({coef_b0, coef_b1, coef_a1} !== 48'h7FFF_0000_0000) begin
      errors++; $display("FAIL reset_coefs got %h %h %h want 7fff 0000 0000", coef_b0, coef_b1, coef_a1); end
    areset = 1'b0;
    tick();
    checks++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      errors++; $display("FAIL ready_after_reset got %b want 111", {s_axi_awready, s_axi_wready, s_axi_arready}); end
    for (int a = 0; a < 4; a++) do_read(4'(a * 4), 0);
  endtask

  task automatic test_write_order();
    do_write(4'h4, 32'h0000_4000, 4'hF, 0, 0, 0);
    do_write(4'hC, 32'h0000_4000, 4'hF, 3, 0, 0);
    do_write(4'h8, 32'h0000_1111, 4'hF, 0, 2, 1);
  endtask

  task automatic test_ctrl_clear();
    do_write(4'h0, 32'h3, 4'hF, 0, 0, 2);
    do_write(4'h0, 32'h1, 4'hF, 0, 0, 0);
    do_read(4'h0, 1);
    do_write(4'h0, 32'h2, 4'h2, 0, 0, 0);
  endtask

  task automatic test_strobe();
    do_write(4'h8, 32'h0000_0000, 4'hF, 0, 0, 0);
    do_write(4'h8, 32'hFFFF_1234, 4'b0001, 0, 0, 0);
    do_write(4'h8, 32'hABCD_5678, 4'b0000, 1, 0, 0);
    do_write(4'h8, 32'h0000_9900, 4'b1110, 0, 1, 0);
    do_read(4'hB, 0);
  endtask

  // B held off; a second AW must wait until the response completes.
  task automatic test_back_to_back();
    do_write(4'h4, 32'h0000_2222, 4'hF, 0, 0, 5);
    s_axi_awaddr = 4'h4; s_axi_wdata = 32'h0000_0BAD; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    model_write(1, 32'h0000_0BAD, 4'hF);
    s_axi_awaddr = 4'hC;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({s_axi_bvalid, s_axi_awready} !== 2'b10) begin
        errors++; $display("FAIL second_aw_blocked got bvalid/awready=%b want 10", {s_axi_bvalid, s_axi_awready}); end
      tick();
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    checks++; if ({s_axi_bvalid, s_axi_awready} !== 2'b01) begin
      errors++; $display("FAIL second_aw_unblocked got %b want 01", {s_axi_bvalid, s_axi_awready}); end
    tick();
    s_axi_awvalid = 1'b0;
    checks++; if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b001) begin
      errors++; $display("FAIL aw_held got bvalid/awready/wready=%b want 001", {s_axi_bvalid, s_axi_awready, s_axi_wready}); end
    s_axi_wdata = 32'h0000_7001; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    model_write(3, 32'h0000_7001, 4'hF);
    checks++; if ({s_axi_bvalid, coef_b0, coef_a1} !== {1'b1, m_coef[1], m_coef[3]}) begin
      errors++; $display("FAIL second_write got %b %h %h want 1 %h %h", s_axi_bvalid, coef_b0, coef_a1, m_coef[1], m_coef[3]); end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    $display("write back-to-back b0=%h a1=%h", m_coef[1], m_coef[3]);
  endtask

  // Read accepted in the commit cycle of a write to the same register sees the old value.
  task automatic test_read_during_write();
    logic [31:0] old_v, new_v;
    old_v = model_read(2);
    new_v = {16'd0, 16'($urandom())};
    s_axi_awaddr = 4'h8; s_axi_wdata = new_v; s_axi_wstrb = 4'hF; s_axi_araddr = 4'h8;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    model_write(2, new_v, 4'hF);
    checks++; if ({s_axi_rvalid, s_axi_rdata} !== {1'b1, old_v}) begin
      errors++; $display("FAIL read_old_value got %b/%h want 1/%h", s_axi_rvalid, s_axi_rdata, old_v); end
    checks++; if ({s_axi_bvalid, coef_b1} !== {1'b1, m_coef[2]}) begin
      errors++; $display("FAIL concurrent_write got %b/%h want 1/%h", s_axi_bvalid, coef_b1, m_coef[2]); end
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    tick();
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    checks++; if ({s_axi_bvalid, s_axi_rvalid} !== 2'b00) begin
      errors++; $display("FAIL concurrent_release got %b want 00", {s_axi_bvalid, s_axi_rvalid}); end
    $display("rw same-cycle old=%h new=%h", old_v, new_v);
  endtask

  task automatic test_reset_midway();
    do_write(4'h0, 32'h1, 4'h1, 0, 0, 0);
    s_axi_awaddr = 4'h4; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wdata = 32'h0000_1357; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    areset = 1'b1;
    tick();
    areset = 1'b0; s_axi_wvalid = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (s_axi_bvalid !== 1'b0) begin errors++; $display("FAIL no_b_after_reset got %b want 0", s_axi_bvalid); end
    end
    checks++; if ({filt_enable, coef_b0, coef_b1, coef_a1} !== {1'b0, 48'h7FFF_0000_0000}) begin
      errors++; $display("FAIL regs_after_reset got %b %h %h %h", filt_enable, coef_b0, coef_b1, coef_a1); end
    do_read(4'h4, 0);
    $display("reset mid-transaction done");
  endtask

  task automatic test_random();
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    for (int n = 0; n < 40; n++) begin
      a = 4'($urandom());
      d = $urandom();
      s = 4'($urandom());
      if ($urandom_range(0, 1) == 1)
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2));
    end
  endtask

  initial begin
    areset = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_write_order();
    test_ctrl_clear();
    test_strobe();
    test_back_to_back();
    test_read_during_write();
    test_reset_midway();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
